// File: rtl/pipe_step_ctrl.sv
// ============================================================================
// Module      : pipe_step_ctrl
// Description : Debug run/step sequencer driving the global pipeline latch
//               enable, with halt drain and saturating executed-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_step_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic             i_stop_pipe,
    output logic             o_step,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_done,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    localparam int             DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] c_drain_load = DRAIN_W'(DRAIN_CYCLES - 1);

    localparam logic [1:0] c_cmd_clr   = 2'b00;
    localparam logic [1:0] c_cmd_run   = 2'b01;
    localparam logic [1:0] c_cmd_step  = 2'b10;
    localparam logic [1:0] c_cmd_abort = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t               r_state;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic                 r_done;
    logic [CNT_W-1:0]     r_cycle_cnt;

    logic w_cmd_acc;
    logic w_run;
    logic w_step;
    logic w_abort;
    logic w_clr;
    logic w_cnt_sat;

    // Outputs decode straight from the state register, so reset clears them
    // asynchronously and no input reaches an output combinationally.
    assign o_step      = (r_state == ST_RUN) || (r_state == ST_STEP) || (r_state == ST_DRAIN);
    assign o_busy      = o_step;
    assign o_halted    = (r_state == ST_HALTED);
    assign o_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_HALTED);
    assign o_done      = r_done;
    assign o_cycle_cnt = r_cycle_cnt;

    assign w_cmd_acc = i_cmd_valid && o_cmd_ready;
    assign w_run     = w_cmd_acc && (i_cmd == c_cmd_run);
    assign w_step    = w_cmd_acc && (i_cmd == c_cmd_step);
    assign w_abort   = w_cmd_acc && (i_cmd == c_cmd_abort);
    assign w_clr     = w_cmd_acc && (i_cmd == c_cmd_clr);
    assign w_cnt_sat = &r_cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_run) begin
                        r_state <= ST_RUN;
                    end else if (w_step) begin
                        r_state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    // A halt reaching EX/MEM outranks a concurrent ABORT.
                    if (i_stop_pipe) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= c_drain_load;
                    end else if (w_abort) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (i_stop_pipe) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= c_drain_load;
                    end else begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state <= ST_HALTED;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end
                ST_HALTED: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
        end else if (w_clr) begin
            r_cycle_cnt <= '0;
        end else if (o_step && !w_cnt_sat) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_step_ctrl.sv
// ============================================================================
// Module      : tb_pipe_step_ctrl
// Description : Self-checking bench for pipe_step_ctrl against a behavioural
//               mode/cycle model, with directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_step_ctrl;

    localparam int CNT_W   = 4;
    localparam int DRAIN   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [1:0] CLR = 2'b00, RUN = 2'b01, STEP = 2'b10, ABORT = 2'b11;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_cmd_valid = 1'b0;
    logic [1:0]       i_cmd = 2'b00;
    logic             o_cmd_ready;
    logic             i_stop_pipe = 1'b0;
    logic             o_step;
    logic             o_busy;
    logic             o_halted;
    logic             o_done;
    logic [CNT_W-1:0] o_cycle_cnt;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_step = 0;

    // behavioural model: current mode, drain cycles still to issue, counter, done flag
    int m_mode = M_IDLE;
    int m_left = 0;
    int m_cnt  = 0;
    int m_done = 0;

    pipe_step_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd       (i_cmd),
        .o_cmd_ready (o_cmd_ready),
        .i_stop_pipe (i_stop_pipe),
        .o_step      (o_step),
        .o_busy      (o_busy),
        .o_halted    (o_halted),
        .o_done      (o_done),
        .o_cycle_cnt (o_cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_ready(input int mode);
        return (mode == M_IDLE || mode == M_RUN || mode == M_HALTED) ? 1 : 0;
    endfunction

    function automatic int exp_step(input int mode);
        return (mode == M_RUN || mode == M_STEP || mode == M_DRAIN) ? 1 : 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = M_IDLE;
                m_left = 0;
                m_cnt  = 0;
                m_done = 0;
            end else begin
                int  mode;
                bit  acc;
                mode   = m_mode;
                acc    = i_cmd_valid && (exp_ready(mode) == 1);
                m_done = 0;
                if (acc && i_cmd == CLR)
                    m_cnt = 0;
                else if (exp_step(mode) == 1 && m_cnt < CNT_MAX)
                    m_cnt = m_cnt + 1;
                case (mode)
                    M_IDLE: begin
                        if (acc && i_cmd == RUN)  m_mode = M_RUN;
                        if (acc && i_cmd == STEP) m_mode = M_STEP;
                    end
                    M_RUN: begin
                        if (i_stop_pipe) begin
                            m_mode = M_DRAIN;
                            m_left = DRAIN;
                        end else if (acc && i_cmd == ABORT) begin
                            m_mode = M_IDLE;
                        end
                    end
                    M_STEP: begin
                        if (i_stop_pipe) begin
                            m_mode = M_DRAIN;
                            m_left = DRAIN;
                        end else begin
                            m_mode = M_IDLE;
                            m_done = 1;
                        end
                    end
                    M_DRAIN: begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_mode = M_HALTED;
                            m_done = 1;
                        end
                    end
                    default: begin
                        if (acc && i_cmd == ABORT) m_mode = M_IDLE;
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("step",   int'(o_step),      exp_step(m_mode));
            chk("busy",   int'(o_busy),      exp_step(m_mode));
            chk("halted", int'(o_halted),    (m_mode == M_HALTED) ? 1 : 0);
            chk("ready",  int'(o_cmd_ready), exp_ready(m_mode));
            chk("done",   int'(o_done),      m_done);
            chk("cnt",    int'(o_cycle_cnt), m_cnt);
            n_done += int'(o_done);
            n_step += int'(o_step);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_halted(input int bound);
        int k = 0;
        while (!o_halted && k < bound) begin
            tick();
            k++;
        end
        chk("halt_timeout", int'(o_halted), 1);
    endtask

    initial begin
        int s0, d0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_step",  int'(o_step),      0);
        chk("rst_ready", int'(o_cmd_ready), 1);
        chk("rst_cnt",   int'(o_cycle_cnt), 0);

        // asynchronous reset in the middle of a RUN
        send(RUN);
        repeat (3) tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_step",  int'(o_step),      0);
        chk("arst_busy",  int'(o_busy),      0);
        chk("arst_ready", int'(o_cmd_ready), 1);
        chk("arst_cnt",   int'(o_cycle_cnt), 0);
        tick();
        rst = 1'b0;

        // three single steps
        d0 = n_done;
        s0 = n_step;
        repeat (3) begin
            send(STEP);
            tick();
            tick();
        end
        chk("step3_cnt",   int'(o_cycle_cnt), 3);
        chk("step3_done",  n_done - d0, 3);
        chk("step3_steps", n_step - s0, 3);
        chk("step3_busy",  int'(o_busy), 0);

        // run, halt flag on the 10th run cycle, drain 2
        send(CLR);
        s0 = n_step;
        d0 = n_done;
        send(RUN);
        repeat (9) tick();
        i_stop_pipe = 1'b1;
        tick();
        i_stop_pipe = 1'b0;
        wait_halted(20);
        tick();
        chk("run_cnt",    int'(o_cycle_cnt), 12);
        chk("run_steps",  n_step - s0, 12);
        chk("run_done",   n_done - d0, 1);
        chk("run_ready",  int'(o_cmd_ready), 1);
        send(ABORT);
        chk("run_abort",  int'(o_halted), 0);

        // ABORT and halt flag together in RUN: stop wins
        send(RUN);
        tick();
        i_cmd_valid = 1'b1;
        i_cmd       = ABORT;
        i_stop_pipe = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        i_stop_pipe = 1'b0;
        chk("race_busy",  int'(o_busy), 1);
        chk("race_ready", int'(o_cmd_ready), 0);
        tick();
        chk("race_still", int'(o_halted), 0);
        tick();
        chk("race_halt",  int'(o_halted), 1);
        send(ABORT);
        chk("race_idle",  int'(o_halted), 0);
        chk("race_stop0", int'(o_step), 0);

        // halt flag inside a STEP cycle
        d0 = n_done;
        s0 = n_step;
        send(STEP);
        i_stop_pipe = 1'b1;
        tick();
        i_stop_pipe = 1'b0;
        wait_halted(10);
        tick();
        chk("stephalt_done",  n_done - d0, 1);
        chk("stephalt_steps", n_step - s0, 3);
        send(ABORT);

        // saturation and clear-while-running
        send(CLR);
        send(RUN);
        repeat (20) tick();
        chk("sat_cnt", int'(o_cycle_cnt), CNT_MAX);
        send(CLR);
        chk("clr_cnt0", int'(o_cycle_cnt), 0);
        tick();
        chk("clr_cnt1", int'(o_cycle_cnt), 1);
        tick();
        chk("clr_cnt2", int'(o_cycle_cnt), 2);
        send(ABORT);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            i_cmd_valid = 1'($urandom_range(0, 1));
            i_cmd       = 2'($urandom_range(0, 3));
            i_stop_pipe = ($urandom_range(0, 9) == 0);
            tick();
        end
        i_cmd_valid = 1'b0;
        i_stop_pipe = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
